cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Parametrised common data bus: NUM_SRC producers (RS ALU, LS buffer, ...) push results into
//  per-source FIFOs; a round-robin arbiter broadcasts one result per cycle on a registered CDB
//  fanned out to issuer, rs_station, ls_buffer and ro_buffer. Adds backpressure and flush.
// PARAMETERS
//  NUM_SRC      2   number of producer channels (>=2)
//  FIFO_DEPTH   4   entries per source FIFO (power of two, >=2)
//  ROB_ID_W     4   width of ROB tag (matches RO_BUFFER_ID_TYPE)
//  XLEN         32  width of value / next_pc
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  rst_n         in   1                 asynchronous active-low reset
//  flush         in   1                 mispredict flush from ro_buffer
//  src_valid     in   NUM_SRC           producer i has a result this cycle
//  src_ready     out  NUM_SRC           FIFO i can accept (count_i < FIFO_DEPTH)
//  src_dest      in   NUM_SRC*ROB_ID_W  ROB tag, source i at [i*ROB_ID_W +: ROB_ID_W]
//  src_value     in   NUM_SRC*XLEN      result value, same packing
//  src_next_pc   in   NUM_SRC*XLEN      resolved next pc, same packing
//  cdb_valid     out  1                 broadcast valid
//  cdb_dest      out  ROB_ID_W          broadcast ROB tag
//  cdb_value     out  XLEN              broadcast value
//  cdb_next_pc   out  XLEN              broadcast next pc (consumed by ro_buffer only)
// BEHAVIOUR
//  - Reset: all FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_dest/value/next_pc=0, src_ready=all 1.
//  - Push: src_valid[i]&&src_ready[i] writes entry to FIFO i at clock edge; src_valid with
//    src_ready low is ignored (producer must hold). src_ready depends on registered count only.
//  - Full FIFO does not accept a push even if popped same cycle (no combinational ready path).
//  - Arbitration, each cycle: scan sources rr_ptr, rr_ptr+1, ... mod NUM_SRC; first non-empty
//    FIFO wins, head popped, entry loaded into cdb_* regs with cdb_valid=1 at next edge.
//    rr_ptr <= (winner+1) mod NUM_SRC on grant; unchanged if no FIFO non-empty (cdb_valid<=0).
//  - Latency: push sampled in cycle t -> earliest cdb_valid in cycle t+2. Throughput 1/cycle.
//  - Push and pop of same FIFO in one cycle: count unchanged, ordering FIFO per source.
//  - Pointer wrap: rd/wr pointers log2(FIFO_DEPTH) bits wrap naturally; count is
//    log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
//  - cdb_* holds last payload when cdb_valid=0; consumers qualify on cdb_valid.
//  - Flush (sync, priority over push/pop): all FIFOs emptied, pushes in flush cycle dropped,
//    cdb_valid<=0, rr_ptr<=0. src_ready all 1 the cycle after.
//  - rst_n low mid-operation: immediate return to reset state regardless of clk.
//  - No starvation: a non-empty source is granted within NUM_SRC cycles.
// STRUCTURE
//  - config.v: RO_BUFFER_ID_TYPE, REG_TYPE, default CDB_NUM_SRC / CDB_FIFO_DEPTH macros.
//  - Sub-module cdb_fifo (one per source via generate): push/pop/flush, count, full/empty,
//    head payload {dest,value,next_pc}. Top holds rr arbiter and output registers.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> cdb_valid=0, src_ready=2'b11, outputs 0 immediately.
//  2 Single push src0 dest=3 value=0x55 at t -> cdb_valid=1,dest=3,value=0x55 at t+2 only.
//  3 Both sources push every cycle (src0 dest 1,2..; src1 dest 9,10..) -> CDB alternates
//    src0,src1,src0,... ; per-source order preserved; rr_ptr toggles.
//  4 Hold src0 valid 6 cycles with src1 saturating, DEPTH=4 -> src_ready[0] drops at count 4,
//    no entry lost or duplicated; scoreboard matches every pushed tag exactly once.
//  5 Fill both FIFOs, assert flush with concurrent push -> next cycle cdb_valid=0, FIFOs empty,
//    flush-cycle push absent from CDB, src_ready=all 1.
//  6 NUM_SRC=3, only src2 active -> granted every cycle, full 1/cycle throughput after t+2.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and helpers for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC    = 2;
  localparam int CDB_FIFO_DEPTH = 4;
  localparam int CDB_ROB_ID_W   = 4;
  localparam int CDB_XLEN       = 32;

  // Round-robin successor of a source index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-source result FIFO: registered count, synchronous flush, head always visible.
module cdb_arbiter_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_DEPTH,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Full/empty come only from the registered count, so ready has no path from pop.
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Payload storage; no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally; flush discards everything including this cycle's push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus: per-source FIFOs, round-robin grant, registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int ROB_ID_W   = CDB_ROB_ID_W,
  parameter int XLEN       = CDB_XLEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*ROB_ID_W-1:0]  src_dest,
  input  logic [NUM_SRC*XLEN-1:0]      src_value,
  input  logic [NUM_SRC*XLEN-1:0]      src_next_pc,
  output logic                         cdb_valid,
  output logic [ROB_ID_W-1:0]          cdb_dest,
  output logic [XLEN-1:0]              cdb_value,
  output logic [XLEN-1:0]              cdb_next_pc
);

  localparam int PAY_W = ROB_ID_W + 2 * XLEN;
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [PAY_W-1:0]   head [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic               grant;

  assign src_ready = ~full;
  assign push      = src_valid & ~full;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_arbiter_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PAY_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata ({src_dest[i*ROB_ID_W +: ROB_ID_W],
               src_value[i*XLEN +: XLEN],
               src_next_pc[i*XLEN +: XLEN]}),
      .full  (full[i]),
      .empty (empty[i]),
      .rdata (head[i])
    );
  end

  // Scan from rr_ptr upward (mod NUM_SRC); the first non-empty FIFO wins and is popped.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    pop    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant && !empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        grant  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
    if (grant && !flush) pop[winner] = 1'b1;
  end

  // Broadcast register and rotating priority; payload holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid   <= 1'b0;
      cdb_dest    <= '0;
      cdb_value   <= '0;
      cdb_next_pc <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (grant) begin
      cdb_valid                             <= 1'b1;
      {cdb_dest, cdb_value, cdb_next_pc}    <= head[winner];
      rr_ptr                                <= PTR_W'(rr_next(int'(winner), NUM_SRC));
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule
